// File: rtl/sr_pkg.sv
// sr_pkg: SR command encodings and next-state helper shared by the SR flip-flop bank
package sr_pkg;
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_INVALID = 2'b11;
  function automatic logic sr_next(input logic [1:0] cmd, input logic q);
    case (cmd)
      SR_SET:   return 1'b1;
      SR_RESET: return 1'b0;
      SR_HOLD, SR_INVALID: return q;
      default:  return q;
    endcase
  endfunction
endpackage

// File: rtl/sr_cell.sv
// sr_cell: one-bit SR flop with sync reset; sticky err output when SR_INVALID_FLAG_EN is defined
module sr_cell
  import sr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qb
`ifdef SR_INVALID_FLAG_EN
  ,
  output logic err
`endif
);
  // reset wins; otherwise set, clear or hold (11 holds)
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : sr_next({s, r}, q);
  assign qb = ~q;
`ifdef SR_INVALID_FLAG_EN
  // sticky flag for 11 commands, cleared only by reset
  always_ff @(posedge clk)
    err <= rst ? 1'b0 : (err | ({s, r} == SR_INVALID));
`endif
endmodule

// File: rtl/sr_flip_flop.sv
// sr_flip_flop: bank of WIDTH independent SR flops with complementary outputs; err port with SR_INVALID_FLAG_EN
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] sr,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qb
`ifdef SR_INVALID_FLAG_EN
  ,
  output logic [WIDTH-1:0]   err
`endif
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_cell u_cell (
      .clk(clk),
      .rst(rst),
      .s(sr[2*i+1]),
      .r(sr[2*i]),
      .q(q[i]),
      .qb(qb[i])
`ifdef SR_INVALID_FLAG_EN
      ,
      .err(err[i])
`endif
    );
  end
endmodule

// File: tb/tb_sr_flip_flop.sv
// tb_sr_flip_flop: directed self-checking bench for a 4-bit sr_flip_flop bank
module tb_sr_flip_flop;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sr  = 8'h00;
  logic [3:0] q, qb;
`ifdef SR_INVALID_FLAG_EN
  logic [3:0] err;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  sr_flip_flop #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .sr(sr),
    .q(q),
    .qb(qb)
`ifdef SR_INVALID_FLAG_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (chk_on) begin
      n_cmp++;
      assert (qb === ~q) else begin
        n_bad++;
        $error("FAIL qb_compl: qb=%b q=%b expected qb=%b", qb, q, ~q);
      end
    end

  task automatic step(input logic r, input logic [7:0] s);
    @(negedge clk);
    rst = r;
    sr  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    chk_on = 1'b1;
    chk("reset_q", q, 4'b0000);
    chk("reset_qb", qb, 4'b1111);
`ifdef SR_INVALID_FLAG_EN
    chk("reset_err", err, 4'b0000);
`endif
    step(1'b0, 8'b00_00_00_10);
    chk("set_b0", q, 4'b0001);
    chk("set_b0_qb", qb, 4'b1110);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00);
    chk("hold_5", q, 4'b0001);
    step(1'b0, 8'b00_00_00_01);
    chk("clr_b0", q, 4'b0000);
    chk("clr_b0_qb", qb, 4'b1111);
    step(1'b0, 8'b00_00_00_01);
    chk("clr_again", q, 4'b0000);
    step(1'b0, 8'b00_00_00_10);
    chk("set_again", q, 4'b0001);
    step(1'b0, 8'b00_00_00_11);
    chk("inv_hold1", q, 4'b0001);
`ifdef SR_INVALID_FLAG_EN
    chk("inv_err", err, 4'b0001);
`endif
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("inv_hold2", q, 4'b0001);
`ifdef SR_INVALID_FLAG_EN
    chk("err_sticky", err, 4'b0001);
`endif
    step(1'b1, 8'b00_00_00_10);
    chk("rst_prio", q, 4'b0000);
`ifdef SR_INVALID_FLAG_EN
    chk("err_clr", err, 4'b0000);
`endif
    step(1'b0, 8'b00_00_00_10);
    chk("post_rst_set", q, 4'b0001);
    step(1'b1, 8'h00);
    chk("rst_again", q, 4'b0000);
    step(1'b0, 8'b10_01_00_10);
    chk("multi_cmd", q, 4'b1001);
    chk("multi_cmd_qb", qb, 4'b0110);
    step(1'b0, 8'b00_10_01_00);
    chk("indep", q, 4'b1101);
    step(1'b0, 8'b11_00_00_00);
    chk("inv_b3", q, 4'b1101);
`ifdef SR_INVALID_FLAG_EN
    chk("err_b3", err, 4'b1000);
`endif
    step(1'b0, 8'hFF);
    chk("inv_all", q, 4'b1101);
`ifdef SR_INVALID_FLAG_EN
    chk("err_all", err, 4'b1111);
`endif
    step(1'b0, 8'b01_01_01_01);
    chk("clr_all", q, 4'b0000);
    step(1'b0, 8'b10_10_10_10);
    chk("set_all", q, 4'b1111);
    chk("set_all_qb", qb, 4'b0000);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
